conv2_maxpool_relu: RTL and testbench

CONV2_MAXPOOL_RELU -- requirements
Module: conv2_maxpool_relu

---
 rtl/conv2_maxpool_relu_pkg.sv | 33 +++
 rtl/conv2_maxpool_relu_pool_lane.sv | 56 +++++
 rtl/conv2_maxpool_relu.sv | 109 ++++++++++
 tb/tb_conv2_maxpool_relu.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv2_maxpool_relu_pkg.sv
// -----------------------------------------------------------------------------
// conv2_maxpool_relu_pkg
// Shared CNN constants for the conv / pool stages and the window-phase type
// used between the pooling top and its per-channel lanes.
//   CONV_K       : conv kernel size (square)
//   CONV1_IMG_W/H: conv1 feature-map size feeding conv2
//   CNN_IMG_W/H  : conv2 feature-map size (pool input), derived from conv1
//   CNN_DW       : sample width of the conv2 / pool datapath
// -----------------------------------------------------------------------------
package conv2_maxpool_relu_pkg;

    localparam int CONV_K      = 3;
    localparam int CONV1_IMG_W = 10;
    localparam int CONV1_IMG_H = 10;
    localparam int CNN_DW      = 12;

    // Valid (no padding) convolution shrinks each dimension by K-1.
    function automatic int conv_out_dim(input int in_dim);
        return in_dim - CONV_K + 1;
    endfunction

    localparam int CNN_IMG_W = conv_out_dim(CONV1_IMG_W);
    localparam int CNN_IMG_H = conv_out_dim(CONV1_IMG_H);

    // What a lane does with the sample arriving this cycle.
    typedef enum logic [1:0] {
        PH_IDLE  = 2'd0,  // no sample accepted
        PH_LATCH = 2'd1,  // even col: hold as left half of the pair
        PH_STORE = 2'd2,  // odd col, even row: top-row pair max to line buffer
        PH_EMIT  = 2'd3   // odd col, odd row: window complete, register result
    } pool_phase_e;

endpackage

// File: rtl/conv2_maxpool_relu_pool_lane.sv
// -----------------------------------------------------------------------------
// pool_lane
// One channel of ReLU + 2x2 max-pool. The top decodes the window phase and the
// line-buffer index from its col/row counters; the lane holds the data.
// Ports:
//   clk, rst        : clock, async active-low reset
//   phase           : action for the current sample (pool_phase_e)
//   buf_idx         : line-buffer entry (col/2)
//   sample_in       : signed conv2 sample
//   pool_out        : registered pooled result, held between windows
// -----------------------------------------------------------------------------
module pool_lane
    import conv2_maxpool_relu_pkg::*;
#(
    parameter int DW    = CNN_DW,
    parameter int IMG_W = CNN_IMG_W,
    parameter int IDX_W = (IMG_W / 2 > 1) ? $clog2(IMG_W / 2) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  pool_phase_e          phase,
    input  logic [IDX_W-1:0]     buf_idx,
    input  logic signed [DW-1:0] sample_in,
    output logic signed [DW-1:0] pool_out
);

    localparam int NBUF = IMG_W / 2;

    logic signed [DW-1:0] relu_val;
    logic signed [DW-1:0] partial;
    logic signed [DW-1:0] pair_max;
    logic signed [DW-1:0] quad_max;
    logic signed [DW-1:0] line_buf [NBUF];

    assign relu_val = sample_in[DW-1] ? '0 : sample_in;
    assign pair_max = (partial > relu_val) ? partial : relu_val;
    assign quad_max = (line_buf[buf_idx] > pair_max) ? line_buf[buf_idx] : pair_max;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            partial  <= '0;
            pool_out <= '0;
            for (int i = 0; i < NBUF; i++) begin
                line_buf[i] <= '0;
            end
        end else begin
            case (phase)
                PH_LATCH: partial           <= relu_val;
                PH_STORE: line_buf[buf_idx] <= pair_max;
                PH_EMIT:  pool_out          <= quad_max;
                default:  ;
            endcase
        end
    end

endmodule

// File: rtl/conv2_maxpool_relu.sv
// -----------------------------------------------------------------------------
// conv2_maxpool_relu
// ReLU followed by 2x2 max-pooling on three conv2 channels streamed in raster
// order. One sample per channel may arrive every cycle; gaps in valid_in
// freeze all state. A pooled result appears one cycle after the sample that
// completes its 2x2 window, flagged by a single-cycle valid_out.
// Ports:
//   clk, rst                  : clock, async active-low reset
//   valid_in                  : conv_in_1..3 carry a sample this cycle
//   conv_in_1..3              : signed conv2 samples, row-major
//   pool_out_1..3             : signed pooled results (MSB always 0)
//   valid_out                 : pool_out_1..3 updated this cycle
//
// Window phase per accepted sample (decoded here, acted on in each lane):
//   phase    | meaning
//   PH_IDLE  | no sample this cycle, everything holds
//   PH_LATCH | even col, keep sample as left half of pair
//   PH_STORE | odd col of even row, pair max into line buffer
//   PH_EMIT  | odd col of odd row, window max to output, valid_out next cycle
// -----------------------------------------------------------------------------
module conv2_maxpool_relu
    import conv2_maxpool_relu_pkg::*;
#(
    parameter int DW    = CNN_DW,
    parameter int IMG_W = CNN_IMG_W,
    parameter int IMG_H = CNN_IMG_H
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    input  logic signed [DW-1:0] conv_in_1,
    input  logic signed [DW-1:0] conv_in_2,
    input  logic signed [DW-1:0] conv_in_3,
    output logic signed [DW-1:0] pool_out_1,
    output logic signed [DW-1:0] pool_out_2,
    output logic signed [DW-1:0] pool_out_3,
    output logic                 valid_out
);

    localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int IDX_W = (IMG_W / 2 > 1) ? $clog2(IMG_W / 2) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic [IDX_W-1:0] buf_idx;
    pool_phase_e      phase;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col <= '0;
            row <= '0;
        end else if (valid_in) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_comb begin
        phase = PH_IDLE;
        if (valid_in) begin
            if (!col[0])      phase = PH_LATCH;
            else if (!row[0]) phase = PH_STORE;
            else              phase = PH_EMIT;
        end
    end

    assign buf_idx = IDX_W'(col >> 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) valid_out <= 1'b0;
        else      valid_out <= (phase == PH_EMIT);
    end

    pool_lane #(.DW(DW), .IMG_W(IMG_W), .IDX_W(IDX_W)) u_lane_1 (
        .clk       (clk),
        .rst       (rst),
        .phase     (phase),
        .buf_idx   (buf_idx),
        .sample_in (conv_in_1),
        .pool_out  (pool_out_1)
    );

    pool_lane #(.DW(DW), .IMG_W(IMG_W), .IDX_W(IDX_W)) u_lane_2 (
        .clk       (clk),
        .rst       (rst),
        .phase     (phase),
        .buf_idx   (buf_idx),
        .sample_in (conv_in_2),
        .pool_out  (pool_out_2)
    );

    pool_lane #(.DW(DW), .IMG_W(IMG_W), .IDX_W(IDX_W)) u_lane_3 (
        .clk       (clk),
        .rst       (rst),
        .phase     (phase),
        .buf_idx   (buf_idx),
        .sample_in (conv_in_3),
        .pool_out  (pool_out_3)
    );

endmodule

// File: tb/tb_conv2_maxpool_relu.sv
// -----------------------------------------------------------------------------
// tb_conv2_maxpool_relu
// Directed + random stimulus for conv2_maxpool_relu. The reference model keeps
// the current frame as a flat array per channel and, whenever an accepted
// sample lands on an odd row and odd column, computes the max of the ReLU'd
// 2x2 window directly from that array.
// -----------------------------------------------------------------------------
module tb_conv2_maxpool_relu;
    import conv2_maxpool_relu_pkg::*;

    localparam int DW = CNN_DW;
    localparam int W  = CNN_IMG_W;
    localparam int H  = CNN_IMG_H;
    localparam int N  = W * H;
    localparam int NP = (W / 2) * (H / 2);

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 valid_in = 1'b0;
    logic signed [DW-1:0] conv_in_1 = '0;
    logic signed [DW-1:0] conv_in_2 = '0;
    logic signed [DW-1:0] conv_in_3 = '0;
    logic signed [DW-1:0] pool_out_1;
    logic signed [DW-1:0] pool_out_2;
    logic signed [DW-1:0] pool_out_3;
    logic                 valid_out;

    always #5 clk = ~clk;

    conv2_maxpool_relu dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .conv_in_1  (conv_in_1),
        .conv_in_2  (conv_in_2),
        .conv_in_3  (conv_in_3),
        .pool_out_1 (pool_out_1),
        .pool_out_2 (pool_out_2),
        .pool_out_3 (pool_out_3),
        .valid_out  (valid_out)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int m_idx    = 0;
    int pulses   = 0;

    logic signed [DW-1:0] mem [3][N];
    logic signed [DW-1:0] last_exp [3];
    logic signed [DW-1:0] cap1 [$];
    logic signed [DW-1:0] cap2 [$];
    logic signed [DW-1:0] cap3 [$];
    logic signed [DW-1:0] ref1 [$];
    logic signed [DW-1:0] ref2 [$];
    logic signed [DW-1:0] ref3 [$];

    function automatic logic signed [DW-1:0] relu_f(input logic signed [DW-1:0] x);
        return (x < 0) ? '0 : x;
    endfunction

    function automatic logic signed [DW-1:0] win_max(input int ch, input int r, input int c);
        logic signed [DW-1:0] m;
        logic signed [DW-1:0] v;
        m = '0;
        for (int dr = 0; dr < 2; dr++) begin
            for (int dc = 0; dc < 2; dc++) begin
                v = relu_f(mem[ch][(r - 1 + dr) * W + (c - 1 + dc)]);
                if (v > m) m = v;
            end
        end
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_caps();
        pulses = 0;
        cap1.delete(); cap2.delete(); cap3.delete();
    endtask

    // One cycle: drive inputs, update the model, check outputs #1 after the edge.
    task automatic send(input bit v, input logic signed [DW-1:0] a,
                        input logic signed [DW-1:0] b, input logic signed [DW-1:0] cc);
        bit done;
        int r;
        int c;
        done      = 1'b0;
        valid_in  = v;
        conv_in_1 = a;
        conv_in_2 = b;
        conv_in_3 = cc;
        if (v) begin
            mem[0][m_idx] = a;
            mem[1][m_idx] = b;
            mem[2][m_idx] = cc;
            r = m_idx / W;
            c = m_idx % W;
            if ((r % 2 == 1) && (c % 2 == 1)) begin
                done = 1'b1;
                for (int ch = 0; ch < 3; ch++) last_exp[ch] = win_max(ch, r, c);
            end
            m_idx = (m_idx + 1) % N;
        end
        @(posedge clk);
        #1;
        check("valid_out", 32'(valid_out), 32'(done));
        check("pool_out_1", pool_out_1, last_exp[0]);
        check("pool_out_2", pool_out_2, last_exp[1]);
        check("pool_out_3", pool_out_3, last_exp[2]);
        if (valid_out === 1'b1) begin
            pulses++;
            cap1.push_back(pool_out_1);
            cap2.push_back(pool_out_2);
            cap3.push_back(pool_out_3);
        end
    endtask

    task automatic send_rand_idle();
        send(1'b0, DW'($urandom), DW'($urandom), DW'($urandom));
    endtask

    task automatic send_ramp(input int k);
        send(1'b1, DW'(k), DW'(N - 1 - k), '0);
    endtask

    task automatic reset_phase(input int n);
        rst = 1'b0;
        #1;
        check("rst_async_valid", 32'(valid_out), 32'd0);
        for (int i = 0; i < n; i++) begin
            valid_in  = 1'($urandom);
            conv_in_1 = DW'($urandom);
            conv_in_2 = DW'($urandom);
            conv_in_3 = DW'($urandom);
            @(posedge clk);
            #1;
            check("rst_valid_out", 32'(valid_out), 32'd0);
            check("rst_pool_out_1", pool_out_1, '0);
            check("rst_pool_out_2", pool_out_2, '0);
            check("rst_pool_out_3", pool_out_3, '0);
        end
        valid_in = 1'b0;
        rst      = 1'b1;
        m_idx    = 0;
        for (int ch = 0; ch < 3; ch++) last_exp[ch] = '0;
    endtask

    task automatic compare_to_ref(input string tag);
        for (int i = 0; i < NP; i++) begin
            check({tag, "_ch1"}, (i < cap1.size()) ? cap1[i] : 'x, ref1[i]);
            check({tag, "_ch2"}, (i < cap2.size()) ? cap2[i] : 'x, ref2[i]);
            check({tag, "_ch3"}, (i < cap3.size()) ? cap3[i] : 'x, ref3[i]);
        end
    endtask

    initial begin
        int accepted;
        for (int ch = 0; ch < 3; ch++) last_exp[ch] = '0;

        // reset with random inputs
        reset_phase(6);
        send_rand_idle();

        // ramp frame
        clear_caps();
        for (int k = 0; k < N; k++) send_ramp(k);
        check("ramp_pulses", pulses, NP);
        check("ramp_first_ch1", (cap1.size() > 0) ? cap1[0] : 'x, 32'd9);
        check("ramp_first_ch2", (cap2.size() > 0) ? cap2[0] : 'x, 32'd63);
        check("ramp_second_ch1", (cap1.size() > 1) ? cap1[1] : 'x, 32'd11);
        check("ramp_fifth_ch1", (cap1.size() > 4) ? cap1[4] : 'x, 32'd25);
        check("ramp_last_ch1", (cap1.size() == NP) ? cap1[NP-1] : 'x, 32'd63);
        check("ramp_last_ch2", (cap2.size() == NP) ? cap2[NP-1] : 'x, 32'd9);
        ref1 = cap1; ref2 = cap2; ref3 = cap3;
        for (int i = 0; i < 3; i++) send_rand_idle();

        // all samples -5: ReLU zeroes everything
        clear_caps();
        for (int k = 0; k < N; k++) send(1'b1, DW'(-5), DW'(-5), DW'(-5));
        check("relu_pulses", pulses, NP);
        for (int i = 0; i < cap1.size(); i++) begin
            check("relu_ch1", cap1[i], '0);
            check("relu_ch3", cap3[i], '0);
        end

        // ramp with valid_in toggling
        clear_caps();
        for (int k = 0; k < N; k++) begin
            send_ramp(k);
            send_rand_idle();
        end
        check("gap_pulses", pulses, NP);
        compare_to_ref("gap");

        // mid-frame reset, then a clean frame
        for (int k = 0; k < 20; k++) send_ramp(k);
        reset_phase(3);
        clear_caps();
        for (int k = 0; k < N; k++) send_ramp(k);
        check("midrst_pulses", pulses, NP);
        compare_to_ref("midrst");

        // two back-to-back frames, no idle
        clear_caps();
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < N; k++) send_ramp(k);
        check("wrap_pulses", pulses, 2 * NP);
        for (int i = 0; i < NP; i++) begin
            check("wrap_ch1", (i + NP < cap1.size()) ? cap1[i + NP] : 'x, ref1[i]);
            check("wrap_ch2", (i + NP < cap2.size()) ? cap2[i + NP] : 'x, ref2[i]);
        end

        // random data (including negatives) with random gaps
        clear_caps();
        accepted = 0;
        while (accepted < 2 * N) begin
            if ($urandom_range(3) != 0) begin
                send(1'b1, DW'($urandom), DW'($urandom), DW'($urandom));
                accepted++;
            end else begin
                send_rand_idle();
            end
        end
        check("rand_pulses", pulses, 2 * NP);
        for (int i = 0; i < cap1.size(); i++) begin
            check("rand_msb_ch1", 32'(cap1[i][DW-1]), 32'd0);
            check("rand_msb_ch2", 32'(cap2[i][DW-1]), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
